// File: rtl/mod_cu.sv
// Control unit for an iterative modulus-by-subtraction datapath.
// Sequences load / compare / subtract / write-back strobes, counts
// subtractions, and flags divide-by-zero or iteration-limit timeout.
module mod_cu #(
  parameter int unsigned W_CNT    = 16,
  parameter int unsigned MAX_ITER = 65535
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic             b_zero,
  input  logic             less_than,
  output logic             isAssgn,
  output logic             isComp,
  output logic             isSub,
  output logic             assgn,
  output logic             isDone,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [W_CNT-1:0] iter_count
);

  localparam logic [W_CNT-1:0] ITER_LIMIT = W_CNT'(MAX_ITER);
  localparam logic [W_CNT-1:0] ITER_ONE   = W_CNT'(1);

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    LOAD  = 4'd1,
    COMP  = 4'd2,
    CHECK = 4'd3,
    SUB   = 4'd4,
    WB    = 4'd5,
    FIN   = 4'd6,
    DONE  = 4'd7,
    ERR   = 4'd8
  } state_t;

  state_t           state_q, state_d;
  logic [W_CNT-1:0] iter_q, iter_d;
  logic             is_assgn_d, is_comp_d, is_sub_d, assgn_d, is_done_d;
  logic             busy_d, done_d, err_d;

  // Next-state, counter update, and Moore decode of the next state so the
  // registered outputs line up with the state they belong to.
  always_comb begin
    state_d    = state_q;
    iter_d     = iter_q;
    is_assgn_d = 1'b0;
    is_comp_d  = 1'b0;
    is_sub_d   = 1'b0;
    assgn_d    = 1'b0;
    is_done_d  = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          iter_d  = '0;
          state_d = b_zero ? ERR : LOAD;
        end
      end
      LOAD:  state_d = COMP;
      COMP:  state_d = CHECK;
      CHECK: begin
        if (less_than)             state_d = FIN;
        else if (iter_q < ITER_LIMIT) state_d = SUB;
        else                       state_d = ERR;
      end
      SUB: begin
        iter_d  = iter_q + ITER_ONE;
        state_d = WB;
      end
      WB:    state_d = COMP;
      FIN:   state_d = DONE;
      DONE:  state_d = IDLE;
      ERR:   state_d = IDLE;
      default: state_d = IDLE;
    endcase

    case (state_d)
      LOAD:    is_assgn_d = 1'b1;
      COMP:    is_comp_d  = 1'b1;
      SUB:     is_sub_d   = 1'b1;
      WB:      assgn_d    = 1'b1;
      FIN:     is_done_d  = 1'b1;
      DONE:    done_d     = 1'b1;
      ERR:     err_d      = 1'b1;
      default: ;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State, counter and output registers; reset wins over every transition.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      iter_q     <= '0;
      isAssgn    <= 1'b0;
      isComp     <= 1'b0;
      isSub      <= 1'b0;
      assgn      <= 1'b0;
      isDone     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state_q    <= state_d;
      iter_q     <= iter_d;
      isAssgn    <= is_assgn_d;
      isComp     <= is_comp_d;
      isSub      <= is_sub_d;
      assgn      <= assgn_d;
      isDone     <= is_done_d;
      busy       <= busy_d;
      done       <= done_d;
      err        <= err_d;
    end
  end

  assign iter_count = iter_q;

endmodule

// File: tb/tb_mod_cu.sv
// Bench for mod_cu: table of directed operations plus hand-written
// sequences for reset mid-loop and start handling around busy.
module tb_mod_cu;

  logic        CLK = 1'b0;
  logic        RST;
  logic        start_r, b_zero_r, sel;
  logic [15:0] a_op, b_op;

  // Instance 1: default parameters, driven by a small subtraction datapath.
  logic        s1, lt1;
  logic        isAssgn1, isComp1, isSub1, assgn1, isDone1, busy1, done1, err1;
  logic [15:0] iter1;
  // Instance 2: MAX_ITER=4 with less_than held at 0 to force a timeout.
  logic        s2;
  logic        isAssgn2, isComp2, isSub2, assgn2, isDone2, busy2, done2, err2;
  logic [7:0]  iter2;

  logic        o_isAssgn, o_isComp, o_isSub, o_assgn, o_isDone, o_busy, o_done, o_err;
  logic [15:0] o_iter;

  logic [15:0] r_reg, diff_reg;

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  assign s1 = start_r & ~sel;
  assign s2 = start_r & sel;

  mod_cu u1 (
    .CLK(CLK), .RST(RST), .start(s1), .b_zero(b_zero_r), .less_than(lt1),
    .isAssgn(isAssgn1), .isComp(isComp1), .isSub(isSub1), .assgn(assgn1),
    .isDone(isDone1), .busy(busy1), .done(done1), .err(err1), .iter_count(iter1)
  );

  mod_cu #(.W_CNT(8), .MAX_ITER(4)) u2 (
    .CLK(CLK), .RST(RST), .start(s2), .b_zero(1'b0), .less_than(1'b0),
    .isAssgn(isAssgn2), .isComp(isComp2), .isSub(isSub2), .assgn(assgn2),
    .isDone(isDone2), .busy(busy2), .done(done2), .err(err2), .iter_count(iter2)
  );

  // Observed outputs of whichever instance the current test targets.
  always_comb begin
    if (sel) begin
      o_isAssgn = isAssgn2; o_isComp = isComp2; o_isSub = isSub2; o_assgn = assgn2;
      o_isDone = isDone2; o_busy = busy2; o_done = done2; o_err = err2;
      o_iter = {8'd0, iter2};
    end else begin
      o_isAssgn = isAssgn1; o_isComp = isComp1; o_isSub = isSub1; o_assgn = assgn1;
      o_isDone = isDone1; o_busy = busy1; o_done = done1; o_err = err1;
      o_iter = iter1;
    end
  end

  // Datapath model: compare flag registered at the end of COMP.
  always @(posedge CLK) begin
    if (RST) begin
      lt1 <= 1'b0;
      r_reg <= 16'd0;
      diff_reg <= 16'd0;
    end else begin
      if (isAssgn1) r_reg <= a_op;
      if (isComp1)  lt1 <= (r_reg < b_op);
      if (isSub1)   diff_reg <= r_reg - b_op;
      if (assgn1)   r_reg <= diff_reg;
    end
  end

  task automatic check(input string name, input int idx, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s[%0d] actual=%0d required=%0d", name, idx, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic check_quiet(input string name, input int idx);
    check({name, "_strobes"}, idx,
          int'({o_isAssgn, o_isComp, o_isSub, o_assgn, o_isDone}), 0);
    check({name, "_busy"}, idx, int'(o_busy), 0);
    check({name, "_done"}, idx, int'(o_done), 0);
    check({name, "_err"},  idx, int'(o_err), 0);
  endtask

  typedef struct {
    bit          sel;
    logic [15:0] a;
    logic [15:0] b;
    bit          bz;
    bit          exp_done;
    int          exp_lat;
    int          exp_subs;
    int          exp_iter;
  } vec_t;

  localparam int NV = 7;
  vec_t vecs [NV];

  // One operation: pulse start, watch every cycle until done/err, then check.
  task automatic run_op(input int idx);
    vec_t v;
    int   n_assgn, n_comp, n_sub, n_wb, n_isdone, n_busy, n_multi, lat;
    bit   finished, got_done, got_err;
    int   exp_comp;
    v = vecs[idx];
    n_assgn = 0; n_comp = 0; n_sub = 0; n_wb = 0; n_isdone = 0;
    n_busy = 0; n_multi = 0; lat = -1;
    finished = 0; got_done = 0; got_err = 0;
    sel = v.sel; a_op = v.a; b_op = v.b; b_zero_r = v.bz; start_r = 1'b1;
    tick();
    start_r = 1'b0; b_zero_r = 1'b0;
    for (int n = 0; n < 200 && !finished; n++) begin
      if (n > 0) tick();
      if ((int'(o_isAssgn) + int'(o_isComp) + int'(o_isSub) + int'(o_assgn) + int'(o_isDone)) > 1)
        n_multi++;
      n_assgn  += int'(o_isAssgn);
      n_comp   += int'(o_isComp);
      n_sub    += int'(o_isSub);
      n_wb     += int'(o_assgn);
      n_isdone += int'(o_isDone);
      n_busy   += int'(o_busy);
      if (o_done || o_err) begin
        finished = 1; lat = n; got_done = o_done; got_err = o_err;
      end
    end
    check("finished", idx, int'(finished), 1);
    exp_comp = v.bz ? 0 : v.exp_subs + 1;
    check("done",      idx, int'(got_done), int'(v.exp_done));
    check("err",       idx, int'(got_err),  int'(!v.exp_done));
    check("latency",   idx, lat,      v.exp_lat);
    check("n_isAssgn", idx, n_assgn,  v.bz ? 0 : 1);
    check("n_isComp",  idx, n_comp,   exp_comp);
    check("n_isSub",   idx, n_sub,    v.exp_subs);
    check("n_assgn",   idx, n_wb,     v.exp_subs);
    check("n_isDone",  idx, n_isdone, int'(v.exp_done));
    check("busy_cyc",  idx, n_busy,   v.exp_lat + 1);
    check("onehot",    idx, n_multi,  0);
    check("iter",      idx, int'(o_iter), v.exp_iter);
    tick();
    check_quiet("after", idx);
    check("iter_hold", idx, int'(o_iter), v.exp_iter);
    sel = 1'b0;
  endtask

  int seen;

  initial begin
    //        sel a      b      bz done lat subs iter
    vecs[0] = '{1'b0, 16'd3,  16'd5, 1'b0, 1'b1, 4,  0, 0};
    vecs[1] = '{1'b0, 16'd17, 16'd5, 1'b0, 1'b1, 16, 3, 3};
    vecs[2] = '{1'b0, 16'd9,  16'd0, 1'b1, 1'b0, 0,  0, 0};
    vecs[3] = '{1'b0, 16'd10, 16'd5, 1'b0, 1'b1, 12, 2, 2};
    vecs[4] = '{1'b0, 16'd4,  16'd1, 1'b0, 1'b1, 20, 4, 4};
    vecs[5] = '{1'b1, 16'd0,  16'd0, 1'b0, 1'b0, 19, 4, 4};
    vecs[6] = '{1'b0, 16'd0,  16'd7, 1'b0, 1'b1, 4,  0, 0};

    RST = 1'b1; start_r = 1'b1; b_zero_r = 1'b0; sel = 1'b0; a_op = 16'd0; b_op = 16'd1;
    tick(); tick();
    // Reset state, with start held high to show reset priority.
    check_quiet("rst_u1", 0);
    check("rst_iter_u1", 0, int'(iter1), 0);
    sel = 1'b1;
    check_quiet("rst_u2", 0);
    check("rst_iter_u2", 0, int'(iter2), 0);
    sel = 1'b0;
    start_r = 1'b0;
    RST = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check_quiet("idle_hold", 0);

    for (int i = 0; i < NV; i++) run_op(i);

    // Reset in WB during the second iteration of 17 mod 5.
    a_op = 16'd17; b_op = 16'd5; start_r = 1'b1;
    tick();
    start_r = 1'b0;
    for (int n = 1; n <= 8; n++) tick();
    check("wb2_assgn", 0, int'(o_assgn), 1);
    check("wb2_iter",  0, int'(o_iter), 2);
    RST = 1'b1; start_r = 1'b1;
    tick();
    check_quiet("rst_mid", 0);
    check("rst_mid_iter", 0, int'(o_iter), 0);
    start_r = 1'b0;
    RST = 1'b0;
    tick(); tick();
    check_quiet("rst_mid_idle", 0);

    // start pulsed during COMP is ignored and not queued.
    a_op = 16'd3; b_op = 16'd5; start_r = 1'b1;
    tick();                     // n=0 LOAD
    start_r = 1'b0;
    tick();                     // n=1 COMP
    check("comp_seen", 0, int'(o_isComp), 1);
    start_r = 1'b1;
    tick();                     // n=2 CHECK
    start_r = 1'b0;
    tick(); tick();             // n=4 DONE
    check("ign_done", 0, int'(o_done), 1);
    tick();                     // n=5 IDLE
    check("ign_idle_busy", 0, int'(o_busy), 0);
    tick();
    check_quiet("ign_not_queued", 0);

    // start held high: next op accepted in the IDLE cycle right after DONE.
    start_r = 1'b1;
    tick();                     // n=0 LOAD
    for (int n = 1; n <= 4; n++) tick();
    check("held_done", 1, int'(o_done), 1);
    tick();                     // IDLE cycle
    check("held_idle", 1, int'(o_busy), 0);
    tick();                     // second op LOAD
    check("held_restart", 1, int'(o_isAssgn), 1);
    start_r = 1'b0;
    seen = 0;
    for (int n = 0; n < 50 && seen == 0; n++) begin
      tick();
      if (o_done) seen = 1;
    end
    check("held_second_done", 1, seen, 1);
    check("held_second_iter", 1, int'(o_iter), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mod_cu.md
MOD_CU -- requirements
Module: mod_cu

Interface
REQ-001 Parameter W_CNT SHALL default to 16; it is the width of the subtraction-iteration counter.
REQ-002 Parameter MAX_ITER SHALL default to 65535; it is the subtraction limit before a timeout error, and it SHALL be ≤ 2^W_CNT−1.
REQ-003 CLK  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 RST  input  1  SHALL be the reset: synchronous, active-high.
REQ-005 start  input  1  SHALL request one modulus operation; it is sampled only in IDLE.
REQ-006 b_zero  input  1  SHALL indicate that the divisor operand is zero; it is sampled together with start.
REQ-007 less_than  input  1  SHALL be the registered compare flag from the datapath.
REQ-008 isAssgn, isComp, isSub, assgn, isDone  output  1 each  SHALL be the datapath operation strobes.
REQ-009 busy  output  1  SHALL be high whenever the state is not IDLE.
REQ-010 done  output  1  SHALL be a one-cycle pulse marking a successful completion.
REQ-011 err  output  1  SHALL be a one-cycle pulse marking divide-by-zero or timeout.
REQ-012 iter_count  output  W_CNT  SHALL report the number of subtractions performed.

Function
REQ-013 The FSM states SHALL be: IDLE, LOAD, COMP, CHECK, SUB, WB, FIN, DONE, ERR.
REQ-014 Strobes SHALL be Moore decodes of the state register; at most one strobe is high per cycle, as follows:
- LOAD→isAssgn
- COMP→isComp
- SUB→isSub
- WB→assgn
- FIN→isDone
- all other states → none
REQ-015 In IDLE with start=1 and b_zero=0, the next state SHALL be LOAD and iter_count SHALL clear to 0.
REQ-016 In IDLE with start=1 and b_zero=1, the next state SHALL be ERR and iter_count SHALL clear to 0; no strobe is issued.
REQ-017 In IDLE with start=0, the FSM SHALL hold in IDLE.
REQ-018 Unconditional transitions SHALL be: LOAD→COMP; COMP→CHECK; SUB→WB; WB→COMP; FIN→DONE; DONE→IDLE; ERR→IDLE.
REQ-019 CHECK SHALL be a strobe-free cycle in which less_than is valid, having been registered at the end of COMP.
REQ-020 From CHECK:
- less_than=1 → FIN
- less_than=0 and iter_count<MAX_ITER → SUB
- less_than=0 and iter_count==MAX_ITER → ERR
REQ-021 iter_count SHALL increment by 1 on each clock edge that leaves SUB; it never wraps, because REQ-020 bounds it.
REQ-022 iter_count SHALL hold its value through DONE, ERR and IDLE until the next accepted start.
REQ-023 done SHALL equal 1 only in state DONE, and err SHALL equal 1 only in state ERR.
REQ-024 Latency: with k = number of subtractions, done SHALL be high during the cycle following the (4+4k)-th rising edge after the edge that accepted start.
REQ-025 start asserted while busy=1 SHALL be ignored, and SHALL NOT be queued.
REQ-026 start held high continuously SHALL cause a new operation to be accepted in the IDLE cycle immediately after DONE or ERR.
REQ-027 less_than and b_zero SHALL have no effect outside the states in which they are sampled.

Reset
REQ-028 With RST=1 at a rising edge, the next state SHALL be IDLE and iter_count SHALL be 0.
REQ-029 While in reset, all strobes, busy, done and err SHALL be 0.
REQ-030 RST SHALL take priority over start and over every state transition, including mid-loop.
REQ-031 After RST deasserts, the block SHALL remain in IDLE until start=1.

Verification
REQ-032 Bench SHALL cover a=3, b=5 (the datapath model returns less_than=1 at the first COMP). Required:
- strobe sequence isAssgn, isComp, (none), isDone
- done high at edge 4+1
- iter_count=0
REQ-033 Bench SHALL cover a=17, b=5. Required:
- exactly 3 isSub/assgn pairs
- done after 16 edges
- iter_count=3
- err=0
REQ-034 Bench SHALL cover start=1 with b_zero=1. Required:
- err pulses one cycle after the start edge
- no strobes are issued
- iter_count=0
- busy high for exactly 1 cycle
REQ-035 Bench SHALL cover MAX_ITER=4 with less_than forced to 0. Required:
- 4 subtractions
- then ERR
- err pulse
- iter_count=4
- done never asserted
REQ-036 Bench SHALL cover RST asserted in WB during the second iteration. Required: on the next cycle, state is IDLE, all outputs are 0, and iter_count=0.
REQ-037 Bench SHALL cover start pulsed during COMP, followed by start held high after DONE. Required:
- the mid-operation pulse is ignored
- a second operation begins one cycle after DONE
